// File: rtl/pico_io_sequencer.sv
// pico_io_sequencer: switch-driven front end for the picoMips transform core.
// Debounces SW8, captures x1/y1, launches the core and shows x2/y2 on LED.
module pico_io_sequencer #(
    parameter int DB_CYCLES      = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic [7:0] sw_data,
    input  logic       sw_go,
    input  logic       core_done,
    input  logic [7:0] x2_in,
    input  logic [7:0] y2_in,
    output logic [7:0] x1,
    output logic [7:0] y1,
    output logic       start,
    output logic [7:0] LED,
    output logic       busy,
    output logic       err
);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_WX = 3'd0;
    localparam logic [2:0] S_RX = 3'd1;
    localparam logic [2:0] S_WY = 3'd2;
    localparam logic [2:0] S_RY = 3'd3;
    localparam logic [2:0] S_GO = 3'd4;
    localparam logic [2:0] S_CW = 3'd5;
    localparam logic [2:0] S_SX = 3'd6;
    localparam logic [2:0] S_SY = 3'd7;

    logic           r_sync;
    logic           r_go_s;
    logic           r_go_db;
    logic           r_go_rise;
    logic           r_go_fall;
    logic [DBW-1:0] r_db_cnt;
    logic [2:0]     r_state;
    logic [TOW-1:0] r_to_cnt;
    logic [7:0]     r_x1;
    logic [7:0]     r_y1;
    logic [7:0]     r_led;
    logic [7:0]     r_y2;
    logic           r_start;
    logic           r_busy;
    logic           r_err;
    logic           w_timeout;

    assign w_timeout = (r_to_cnt == TO_LAST);

    // Edge pulses are registered so they line up with the go_db change.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_sync    <= 1'b0;
            r_go_s    <= 1'b0;
            r_go_db   <= 1'b0;
            r_db_cnt  <= '0;
            r_go_rise <= 1'b0;
            r_go_fall <= 1'b0;
        end else begin
            r_sync    <= sw_go;
            r_go_s    <= r_sync;
            r_go_rise <= 1'b0;
            r_go_fall <= 1'b0;
            if (r_go_s == r_go_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_cnt  <= '0;
                r_go_db   <= r_go_s;
                r_go_rise <= r_go_s;
                r_go_fall <= ~r_go_s;
            end else begin
                r_db_cnt <= r_db_cnt + DBW'(1);
            end
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state  <= S_WX;
            r_to_cnt <= '0;
            r_x1     <= 8'd0;
            r_y1     <= 8'd0;
            r_led    <= 8'd0;
            r_y2     <= 8'd0;
            r_start  <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_WX: if (r_go_rise) begin
                    r_x1    <= sw_data;
                    r_err   <= 1'b0;
                    r_state <= S_RX;
                end
                S_RX: if (r_go_fall) r_state <= S_WY;
                S_WY: if (r_go_rise) begin
                    r_y1    <= sw_data;
                    r_state <= S_RY;
                end
                // start and busy become visible together in the GO cycle
                S_RY: if (r_go_fall) begin
                    r_start  <= 1'b1;
                    r_busy   <= 1'b1;
                    r_to_cnt <= '0;
                    r_state  <= S_GO;
                end
                S_GO: begin
                    r_to_cnt <= '0;
                    r_state  <= S_CW;
                end
                S_CW: if (core_done) begin
                    r_y2    <= y2_in;
                    r_led   <= x2_in;
                    r_busy  <= 1'b0;
                    r_state <= S_SX;
                end else if (w_timeout) begin
                    r_led   <= 8'hFF;
                    r_err   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_WX;
                end else begin
                    r_to_cnt <= r_to_cnt + TOW'(1);
                end
                S_SX: if (r_go_rise) begin
                    r_led   <= r_y2;
                    r_state <= S_SY;
                end
                S_SY: if (r_go_fall) r_state <= S_WX;
                default: r_state <= S_WX;
            endcase
        end
    end

    assign x1    = r_x1;
    assign y1    = r_y1;
    assign start = r_start;
    assign LED   = r_led;
    assign busy  = r_busy;
    assign err   = r_err;

endmodule

// File: tb/tb_pico_io_sequencer.sv
// tb_pico_io_sequencer: vector table, corner sequences and random operator
// traffic, all checked against a cycle-level model of the switch protocol.
module tb_pico_io_sequencer;

    localparam int DB = 4;
    localparam int TO = 10;

    logic       Clock = 1'b0;
    logic       nReset = 1'b0;
    logic [7:0] sw_data = 8'd0;
    logic       sw_go = 1'b0;
    logic       core_done = 1'b0;
    logic [7:0] x2_in = 8'd0;
    logic [7:0] y2_in = 8'd0;
    logic [7:0] x1;
    logic [7:0] y1;
    logic       start;
    logic [7:0] LED;
    logic       busy;
    logic       err;

    int n_chk = 0;
    int n_fail = 0;

    pico_io_sequencer #(
        .DB_CYCLES      (DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .sw_data   (sw_data),
        .sw_go     (sw_go),
        .core_done (core_done),
        .x2_in     (x2_in),
        .y2_in     (y2_in),
        .x1        (x1),
        .y1        (y1),
        .start     (start),
        .LED       (LED),
        .busy      (busy),
        .err       (err)
    );

    always #5 Clock = ~Clock;

    // Reference model: operator phase plus a window of synchronized samples
    typedef enum int {M_WX, M_RX, M_WY, M_RY, M_GO, M_CW, M_SX, M_SY} mph_t;
    mph_t       m_ph = M_WX;
    bit         m_on = 1'b0;
    bit         m_s1, m_db, m_rise, m_fall;
    bit         gs_q[$];
    logic [7:0] m_x1, m_y1, m_led, m_y2;
    bit         m_start, m_busy, m_err;
    int         m_cw;

    task automatic m_reset();
        m_on = 1'b1;
        m_s1 = 1'b0;
        gs_q.delete();
        gs_q.push_back(1'b0);
        m_db = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_ph = M_WX;
        m_x1 = 8'd0;
        m_y1 = 8'd0;
        m_led = 8'd0;
        m_y2 = 8'd0;
        m_start = 1'b0;
        m_busy = 1'b0;
        m_err = 1'b0;
        m_cw = 0;
    endtask

    task automatic m_step();
        bit rise, fall, flip;
        rise = m_rise;
        fall = m_fall;
        flip = (gs_q.size() >= DB);
        for (int k = 0; k < DB && k < gs_q.size(); k++)
            if (gs_q[gs_q.size() - 1 - k] == m_db) flip = 1'b0;
        m_rise = flip && !m_db;
        m_fall = flip && m_db;
        if (flip) m_db = !m_db;
        gs_q.push_back(m_s1);
        m_s1 = sw_go;
        while (gs_q.size() > DB) void'(gs_q.pop_front());
        m_start = 1'b0;
        case (m_ph)
            M_WX: if (rise) begin
                m_x1 = sw_data; m_err = 1'b0; m_ph = M_RX;
            end
            M_RX: if (fall) m_ph = M_WY;
            M_WY: if (rise) begin
                m_y1 = sw_data; m_ph = M_RY;
            end
            M_RY: if (fall) begin
                m_start = 1'b1; m_busy = 1'b1; m_ph = M_GO;
            end
            M_GO: begin
                m_cw = 0; m_ph = M_CW;
            end
            M_CW: if (core_done) begin
                m_led = x2_in; m_y2 = y2_in; m_busy = 1'b0; m_ph = M_SX;
            end else if (m_cw + 1 == TO) begin
                m_led = 8'hFF; m_err = 1'b1; m_busy = 1'b0; m_ph = M_WX;
            end else begin
                m_cw++;
            end
            M_SX: if (rise) begin
                m_led = m_y2; m_ph = M_SY;
            end
            M_SY: if (fall) m_ph = M_WX;
            default: m_ph = M_WX;
        endcase
    endtask

    always @(posedge Clock or negedge nReset) begin
        if (!nReset) m_reset();
        else m_step();
    end

    always @(negedge Clock) begin
        if (m_on) begin
            n_chk++;
            if ({x1, y1, start, LED, busy, err} !==
                {m_x1, m_y1, m_start, m_led, m_busy, m_err}) begin
                n_fail++;
                $display("FAIL lockstep t=%0t got x1=%h y1=%h st=%b LED=%h bsy=%b err=%b want x1=%h y1=%h st=%b LED=%h bsy=%b err=%b",
                         $time, x1, y1, start, LED, busy, err,
                         m_x1, m_y1, m_start, m_led, m_busy, m_err);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Core stand-in: answers resp_lat cycles after start (0 = never)
    int         resp_lat = 0;
    int         resp_cnt = 0;
    logic [7:0] resp_x2 = 8'd0;
    logic [7:0] resp_y2 = 8'd0;
    int         n_start = 0;

    task automatic cyc();
        @(posedge Clock);
        #2;
        core_done = 1'b0;
        x2_in = 8'($urandom);
        y2_in = 8'($urandom);
        if (start) n_start++;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                core_done = 1'b1;
                x2_in = resp_x2;
                y2_in = resp_y2;
            end
        end
        if (start && resp_lat > 0) resp_cnt = resp_lat;
    endtask

    task automatic step(input logic go, input logic [7:0] d, input int n);
        sw_go = go;
        sw_data = d;
        repeat (n) cyc();
    endtask

    typedef struct {
        logic       go;
        logic [7:0] data;
        int         lat;
        logic [7:0] rx2;
        logic [7:0] ry2;
        int         hold;
        logic [7:0] ex1;
        logic [7:0] ey1;
        logic [7:0] eled;
        logic       ebusy;
        logic       eerr;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        int first, nchg;
        logic [7:0] prev;

        tbl[0]  = '{1'b1, 8'd40, 3,  8'd60, 8'hDE, 12, 8'd40, 8'd0,  8'd0,  1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'd99, 3,  8'd60, 8'hDE, 12, 8'd40, 8'd0,  8'd0,  1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'd20, 3,  8'd60, 8'hDE, 12, 8'd40, 8'd20, 8'd0,  1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'd0,  3,  8'd60, 8'hDE, 12, 8'd40, 8'd20, 8'd60, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'd0,  3,  8'd60, 8'hDE, 12, 8'd40, 8'd20, 8'hDE, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'd0,  3,  8'd60, 8'hDE, 12, 8'd40, 8'd20, 8'hDE, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 8'd5,  0,  8'd0,  8'd0,  12, 8'd5,  8'd20, 8'hDE, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 8'd0,  0,  8'd0,  8'd0,  12, 8'd5,  8'd20, 8'hDE, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'd7,  0,  8'd0,  8'd0,  12, 8'd5,  8'd7,  8'hDE, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 8'd0,  0,  8'd0,  8'd0,  20, 8'd5,  8'd7,  8'hFF, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 8'd9,  0,  8'd0,  8'd0,  12, 8'd9,  8'd7,  8'hFF, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 8'd0,  0,  8'd0,  8'd0,  12, 8'd9,  8'd7,  8'hFF, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 8'd11, 0,  8'd0,  8'd0,  12, 8'd9,  8'd11, 8'hFF, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 8'd0,  TO, 8'h33, 8'h44, 20, 8'd9,  8'd11, 8'h33, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 8'd0,  TO, 8'h33, 8'h44, 12, 8'd9,  8'd11, 8'h44, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 8'd0,  TO, 8'h33, 8'h44, 12, 8'd9,  8'd11, 8'h44, 1'b0, 1'b0};

        cyc();
        cyc();
        nReset = 1'b1;
        chk("reset x1", x1, 8'd0);
        chk("reset y1", y1, 8'd0);
        chk("reset LED", LED, 8'd0);
        chk("reset ctl", {start, busy, err}, 3'b000);
        cyc();

        n_start = 0;
        for (int i = 0; i < 16; i++) begin
            resp_lat = tbl[i].lat;
            resp_x2 = tbl[i].rx2;
            resp_y2 = tbl[i].ry2;
            step(tbl[i].go, tbl[i].data, tbl[i].hold);
            chk($sformatf("row%0d x1", i), x1, tbl[i].ex1);
            chk($sformatf("row%0d y1", i), y1, tbl[i].ey1);
            chk($sformatf("row%0d LED", i), LED, tbl[i].eled);
            chk($sformatf("row%0d busy", i), busy, tbl[i].ebusy);
            chk($sformatf("row%0d err", i), err, tbl[i].eerr);
            if (i == 5) chk("full pass starts", n_start, 1);
        end
        chk("table starts", n_start, 3);

        // stray core_done in WX
        resp_lat = 0;
        cyc();
        core_done = 1'b1;
        x2_in = 8'h77;
        cyc();
        cyc();
        chk("stray done LED", LED, 8'h44);
        chk("stray done x1", x1, 8'd9);

        // bounce then hold high: one capture, 3 + DB cycles after last edge
        sw_data = 8'hA5;
        sw_go = 1'b1;
        cyc();
        sw_go = 1'b0;
        cyc();
        sw_go = 1'b1;
        first = -1;
        nchg = 0;
        prev = x1;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            if (x1 !== prev) nchg++;
            if (x1 === 8'hA5 && first < 0) first = k;
            prev = x1;
        end
        chk("bounce capture cycle", first, DB + 3);
        chk("bounce capture count", nchg, 1);
        step(1'b0, 8'h00, 10);

        // switch raised during CW, timeout, then go_fall in WX is ignored
        step(1'b1, 8'h12, 10);
        step(1'b0, 8'h00, 8);
        step(1'b1, 8'h66, 14);
        chk("cw edge LED", LED, 8'hFF);
        chk("cw edge err", err, 1'b1);
        chk("cw edge busy", busy, 1'b0);
        chk("cw edge x1", x1, 8'hA5);
        step(1'b0, 8'h66, 10);
        chk("wx fall x1", x1, 8'hA5);
        chk("wx fall LED", LED, 8'hFF);
        step(1'b1, 8'h3C, 10);
        chk("recapture x1", x1, 8'h3C);
        chk("recapture err", err, 1'b0);
        step(1'b0, 8'h00, 10);

        // reset while computing
        step(1'b1, 8'h21, 10);
        step(1'b0, 8'h00, 9);
        chk("cw busy", busy, 1'b1);
        nReset = 1'b0;
        #1;
        chk("rst x1", x1, 8'd0);
        chk("rst y1", y1, 8'd0);
        chk("rst LED", LED, 8'd0);
        chk("rst ctl", {start, busy, err}, 3'b000);
        sw_go = 1'b1;
        sw_data = 8'h4D;
        cyc();
        cyc();
        nReset = 1'b1;
        n_start = 0;
        repeat (12) cyc();
        chk("post rst starts", n_start, 0);
        chk("post rst x1", x1, 8'h4D);
        chk("post rst y1", y1, 8'd0);

        // random operator traffic
        for (int i = 0; i < 80; i++) begin
            resp_lat = $urandom_range(0, 13);
            resp_x2 = 8'($urandom);
            resp_y2 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) begin
                    sw_go = 1'($urandom);
                    sw_data = 8'($urandom);
                    cyc();
                end
            end
            sw_go = ~sw_go;
            sw_data = 8'($urandom);
            repeat ($urandom_range(2, 14)) begin
                cyc();
                sw_data = 8'($urandom);
                if ($urandom_range(0, 15) == 0) core_done = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) begin
                nReset = 1'b0;
                cyc();
                nReset = 1'b1;
            end
        end
        repeat (5) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
